mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative multiply/divide unit in the EX stage; computes MULT/MULTU/DIV/DIVU
//  and produces the 64-bit {hi,lo} result that writeback commits to HI/LO.
//  Holds the pipeline via busy while iterating; results go to the EX-stage HI/LO write path.
// PARAMETERS
//  WIDTH   32  operand width; hi/lo are WIDTH each; counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk      in   1      clock, all state on rising edge
//  resetn   in   1      asynchronous, active-low reset
//  start    in   1      request; sampled only in IDLE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (captured with start)
//  src_a    in   WIDTH  multiplicand / dividend (captured with start)
//  src_b    in   WIDTH  multiplier / divisor (captured with start)
//  flush    in   1      cancel in-flight op (exception/branch squash)
//  busy     out  1      high while an op is in flight; EX stalls on it
//  done     out  1      one-cycle pulse: hi/lo valid this cycle
//  hi_o     out  WIDTH  mult: product[63:32]; div: remainder
//  lo_o     out  WIDTH  mult: product[31:0];  div: quotient
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, hi_o=0, lo_o=0, counter=0.
//  - FSM IDLE->MUL (op[1]=0) or IDLE->DIV (op[1]=1) on start; MUL/DIV->DONE when
//    counter reaches WIDTH; DONE->IDLE next cycle. start while not IDLE ignored.
//  - busy = (state != IDLE) including DONE=0? No: busy=1 in MUL,DIV; 0 in IDLE,DONE.
//  - done=1 only in DONE; hi_o/lo_o registered on entry to DONE, held until next done.
//  - Signed ops: operands converted to magnitude at capture; product sign a^b;
//    quotient sign a^b; remainder sign = sign of a. Fix-up applied on DIV/MUL->DONE.
//  - MUL (slow): shift-add, one bit per cycle, WIDTH cycles.
//  - DIV: restoring radix-2, one quotient bit per cycle, WIDTH cycles.
//  - Latency: start at cycle 0 -> done at cycle WIDTH+1 (33) for both op classes.
//  - Divide by zero: no fault; lo_o=all ones, hi_o=src_a, same latency.
//  - Signed overflow 0x8000_0000 / -1: lo_o=0x8000_0000, hi_o=0.
//  - flush: any state -> IDLE next cycle, done never pulses, hi_o/lo_o unchanged.
//    flush with start in IDLE same cycle: flush wins, op not accepted.
//  - resetn low mid-op: immediate return to reset values, op discarded.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined: MULT/MULTU use a single-cycle WIDTHxWIDTH multiplier;
//    IDLE->DONE directly, done at cycle 1, busy never asserted for multiply.
//  Not defined: multiply is the WIDTH-cycle shift-add path above. DIV unaffected.
// STRUCTURE
//  mdu_pkg: op encoding localparams (OP_MULT..OP_DIVU), state enum
//    (ST_IDLE, ST_MUL, ST_DIV, ST_DONE), sign-fixup helper function.
//  Sub-module mdu_div_step: combinational one-bit restoring step
//    (partial remainder, divisor -> next remainder, quotient bit).
//  Top holds FSM, counter, operand/accumulator registers, mul datapath.
// TESTING
//  1 MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF -> done@33, hi=0xFFFF_FFFE lo=0x0000_0001
//  2 MULT a=-3 b=7 -> hi=0xFFFF_FFFF lo=0xFFFF_FFEB; with MDU_FAST_MUL_EN done@1
//  3 DIV a=-7 b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); DIVU 100/7 -> lo=14 hi=2
//  4 DIV a=0x8000_0000 b=-1 -> lo=0x8000_0000 hi=0; DIVU a=5 b=0 -> lo=0xFFFF_FFFF hi=5
//  5 DIV started, flush at cycle 10 -> IDLE@11, no done, hi/lo keep prior values;
//    new start@12 completes normally at cycle 45
//  6 start re-asserted while busy -> ignored; resetn low at cycle 5 -> all outputs 0

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   OP_*        op encodings presented on the op port
//   mdu_state_e controller states
//   f_sign_fix  conditional two's-complement negate of a double-width value
// MDU_W is the operand width the double-width helper is sized for. mdu_iter
// defaults its WIDTH to it, and the product fix-up assumes the two match.
package mdu_pkg;

   localparam int MDU_W = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   function automatic logic [2*MDU_W-1:0] f_sign_fix(input logic [2*MDU_W-1:0] v,
                                                     input logic             neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//   master (EX stage): drives start, op, src_a, src_b and flush; receives busy, done, hi_o and lo_o
//   slave  (mdu_iter): the reverse directions
interface mdu_iter_if #(parameter int WIDTH = 32) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (output start, op, src_a, src_b, flush,
                   input  busy, done, hi_o, lo_o);

   modport slave  (input  start, op, src_a, src_b, flush,
                   output busy, done, hi_o, lo_o);

endinterface

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division step. This block is purely combinational.
//   i_rem   current partial remainder (always less than i_div)
//   i_msb   next dividend bit, shifted in at the bottom
//   i_div   divisor magnitude
//   o_rem   next partial remainder
//   o_qbit  quotient bit produced by this step
module mdu_div_step #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_msb,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   assign w_shift = {i_rem, i_msb};
   assign w_diff  = w_shift - {1'b0, i_div};
   // The shifted remainder is below 2*divisor, so the top bit of the
   // difference is set exactly when the subtraction underflowed.
   assign o_qbit  = ~w_diff[WIDTH];
   assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) in the EX stage.
// It produces {hi,lo}. For multiply this is the product. For divide it is the remainder and the quotient.
//   clk, resetn  clock and asynchronous active-low reset
//   bus (slave)  start/op/src_a/src_b/flush in; busy/done/hi_o/lo_o out
// Build option MDU_FAST_MUL_EN: multiply uses a single-cycle multiplier
// and goes straight from IDLE to DONE. Divide always iterates.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | waiting for start
//   ST_MUL  | shift-add multiply, one multiplier bit per cycle
//   ST_DIV  | restoring divide, one quotient bit per cycle
//   ST_DONE | hi_o/lo_o valid, done pulses for this cycle
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_W
) (
   input  logic      clk,
   input  logic      resetn,
   mdu_iter_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   mdu_state_e       r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hi, r_lo;       // mul: product accumulator; div: {remainder, dividend/quotient}
   logic [WIDTH-1:0] r_opnd;           // mul: multiplicand magnitude; div: divisor magnitude
   logic             r_neg_q, r_neg_r, r_divz;
   logic [WIDTH-1:0] r_hi_o, r_lo_o;

   logic             w_cap, w_fin, w_last;
   logic             w_is_div, w_sgn;
   logic [WIDTH-1:0] w_mag_a, w_mag_b;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH-1:0] w_div_rem;
   logic             w_div_qbit;
   logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0] w_res_hi, w_res_lo;

   assign w_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   assign w_sgn    = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign w_mag_a  = (w_sgn && bus.src_a[WIDTH-1]) ? (~bus.src_a + 1'b1) : bus.src_a;
   assign w_mag_b  = (w_sgn && bus.src_b[WIDTH-1]) ? (~bus.src_b + 1'b1) : bus.src_b;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_cap       = 1'b0;
      w_fin       = 1'b0;
      if (bus.flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.start) begin
               w_cap = 1'b1;
`ifdef MDU_FAST_MUL_EN
               w_state_nxt = w_is_div ? ST_DIV : ST_DONE;
`else
               w_state_nxt = w_is_div ? ST_DIV : ST_MUL;
`endif
            end
            ST_MUL, ST_DIV: if (w_last) begin
               w_fin       = 1'b1;
               w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .i_rem  (r_hi),
      .i_msb  (r_lo[WIDTH-1]),
      .i_div  (r_opnd),
      .o_rem  (w_div_rem),
      .o_qbit (w_div_qbit)
   );

   // Shift-add: add the multiplicand when the current multiplier bit is set,
   // then shift the whole {hi,lo} pair right by one.
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

   always_comb begin
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (r_state == ST_MUL) begin
         w_hi_nxt = w_mul_sum[WIDTH:1];
         w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end else if (r_state == ST_DIV) begin
         w_hi_nxt = w_div_rem;
         w_lo_nxt = {r_lo[WIDTH-2:0], w_div_qbit};
      end
   end

   // With a zero divisor the remainder naturally ends up equal to the dividend
   // magnitude, so only the quotient needs overriding.
   assign w_prod_fix = f_sign_fix({w_hi_nxt, w_lo_nxt}, r_neg_q);

   always_comb begin
      w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod_fix[WIDTH-1:0];
      if (r_state == ST_DIV) begin
         w_res_hi = r_neg_r ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
         w_res_lo = r_divz ? '1 : (r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_opnd  <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_divz  <= 1'b0;
         r_hi_o  <= '0;
         r_lo_o  <= '0;
      end else if (w_cap) begin
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= w_is_div ? w_mag_a : w_mag_b;
         r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
         r_neg_q <= w_sgn & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
         r_neg_r <= w_sgn & bus.src_a[WIDTH-1];
         r_divz  <= (bus.src_b == '0);
`ifdef MDU_FAST_MUL_EN
         if (!w_is_div) begin
            {r_hi_o, r_lo_o} <= f_sign_fix({{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b},
                                           w_sgn & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]));
         end
`endif
      end else if (!bus.flush && (r_state == ST_MUL || r_state == ST_DIV)) begin
         r_cnt <= r_cnt + 1'b1;
         r_hi  <= w_hi_nxt;
         r_lo  <= w_lo_nxt;
         if (w_fin) begin
            r_hi_o <= w_res_hi;
            r_lo_o <= w_res_lo;
         end
      end
   end

   assign bus.busy = (r_state == ST_MUL) || (r_state == ST_DIV);
   assign bus.done = (r_state == ST_DONE);
   assign bus.hi_o = r_hi_o;
   assign bus.lo_o = r_lo_o;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter. The expected results below were worked out by hand.
module tb_mdu_iter;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   mdu_iter_if #(.WIDTH(32)) bus ();

   mdu_iter #(.WIDTH(32)) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // This task is called in an IDLE cycle, which becomes cycle 0. It asserts start for that cycle.
   // done is expected in cycle exp_lat. If restart_at > 0, a conflicting MULTU 2*2 start is re-asserted for one cycle while busy.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int restart_at);
      int lat;
      lat = -1;
      bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         bus.start = 1'b0;
         if (c == restart_at) begin
            bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd2; bus.src_b = 32'd2;
         end
         if (c == 1) check({tag, "_busy"}, 64'(bus.busy), 64'(exp_lat > 1));
         if (bus.done) begin
            lat = c;
            break;
         end
      end
      bus.start = 1'b0;
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_hi"}, 64'(bus.hi_o), 64'(exp_hi));
      check({tag, "_lo"}, 64'(bus.lo_o), 64'(exp_lo));
      tick();
      check({tag, "_done_pulse"}, 64'({bus.done, bus.busy}), 64'(0));
      check({tag, "_hold"}, {bus.hi_o, bus.lo_o}, {exp_hi, exp_lo});
   endtask

   initial begin
      logic seen_done;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
      bus.src_a = '0;   bus.src_b = '0;

      tick(); tick();
      check("reset_outs", {30'd0, bus.busy, bus.done}, 64'd0);
      check("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
      resetn = 1'b1;
      tick();

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 0);
      run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,        MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
      run_op("mult_nn",   2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFB, MUL_LAT, 32'h0, 32'd10, 0);
      run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,        DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      run_op("divu_100",  2'b11, 32'd100,      32'd7,        DIV_LAT, 32'd2, 32'd14, 0);
      run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0, 32'h8000_0000, 0);
      run_op("divu_zero", 2'b11, 32'd5,        32'd0,        DIV_LAT, 32'd5, 32'hFFFF_FFFF, 0);
      run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'd0,       DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

      // A DIV is flushed in cycle 10. The unit must be IDLE in cycle 11 with no done pulse, and the outputs keep their old values.
      seen_done = 1'b0;
      bus.op = 2'b10; bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         tick();
         bus.start = 1'b0;
         if (bus.done) seen_done = 1'b1;
         if (c == 10) begin
            check("flush_busy_before", 64'(bus.busy), 64'd1);
            bus.flush = 1'b1;
         end
         if (c == 11) begin
            check("flush_idle", 64'(bus.busy), 64'd0);
            bus.flush = 1'b0;
         end
      end
      tick();
      // The new op starts in cycle 12, so done is expected in cycle 45 (33 cycles later).
      run_op("flush_restart", 2'b11, 32'd1000, 32'd3, DIV_LAT, 32'd1, 32'd333, 0);
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.done) seen_done = 1'b1;
      end
      check("flush_no_done", 64'(seen_done), 64'd0);

      // When flush and start arrive together in IDLE, flush wins and the op is not accepted.
      bus.op = 2'b10; bus.src_a = 32'd50; bus.src_b = 32'd5; bus.start = 1'b1; bus.flush = 1'b1;
      tick();
      bus.start = 1'b0; bus.flush = 1'b0;
      check("flush_start_busy", 64'(bus.busy), 64'd0);
      seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.done || bus.busy) seen_done = 1'b1;
      end
      check("flush_start_idle", 64'(seen_done), 64'd0);
      check("flush_start_hilo", {bus.hi_o, bus.lo_o}, {32'd1, 32'd333});

      // start re-asserted while busy must be ignored.
      run_op("restart_ign", 2'b11, 32'd9, 32'd2, DIV_LAT, 32'd1, 32'd4, 3);

      // resetn is pulled low in cycle 5 of a DIV. All outputs must clear and the op must be discarded.
      bus.op = 2'b10; bus.src_a = 32'hFFFF_FFF9; bus.src_b = 32'd2; bus.start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         bus.start = 1'b0;
      end
      resetn = 1'b0;
      #1;
      check("rst_mid_outs", {30'd0, bus.busy, bus.done}, 64'd0);
      check("rst_mid_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
      tick();
      resetn = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.done || bus.busy) seen_done = 1'b1;
      end
      check("rst_mid_discard", 64'(seen_done), 64'd0);

      run_op("after_rst", 2'b01, 32'd6, 32'd7, MUL_LAT, 32'd0, 32'd42, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
